// File: rtl/mar_pkg.sv
// Shared types and default sizing for the burst memory address register.
// Optional wrapping bursts are selected with MAR_WRAP_BURST_EN (see mar_addr_inc).
package mar_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } mar_state_e;

    localparam int MAR_ADDR_W_DEF = 5;
    localparam int MAR_LEN_W_DEF  = 3;
    localparam int MAR_STRIDE_DEF = 1;

endpackage

// File: rtl/mar_addr_inc.sv
// Combinational next-address generator for burst sequencing.
// MAR_WRAP_BURST_EN: only the low LEN_W bits advance, upper bits are held.
module mar_addr_inc
    import mar_pkg::*;
#(
    parameter int ADDR_W = MAR_ADDR_W_DEF,
    parameter int LEN_W  = MAR_LEN_W_DEF,
    parameter int STRIDE = MAR_STRIDE_DEF
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] next_o
);

`ifdef MAR_WRAP_BURST_EN
    localparam logic [LEN_W-1:0] STEP_LO = LEN_W'(STRIDE);

    logic [LEN_W-1:0] low_next;

    // Wrap within the aligned 2^LEN_W block for critical-word-first fills.
    assign low_next = addr_i[LEN_W-1:0] + STEP_LO;
    assign next_o   = {addr_i[ADDR_W-1:LEN_W], low_next};
`else
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    assign next_o = addr_i + STEP;
`endif

endmodule

// File: rtl/mar_burst.sv
// Memory address register with load handshake and burst issue over valid/ready.
// Burst addressing mode is chosen in mar_addr_inc by MAR_WRAP_BURST_EN.
module mar_burst
    import mar_pkg::*;
#(
    parameter int ADDR_W = MAR_ADDR_W_DEF,
    parameter int LEN_W  = MAR_LEN_W_DEF,
    parameter int STRIDE = MAR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic              abort,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_last,
    output logic              busy
);

    mar_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_next;

    mar_addr_inc #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_inc (
        .addr_i (addr_q),
        .next_o (addr_next)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d  = ld_addr;
                    rem_d   = ld_len;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Abort wins; a coincident handshake still completes that beat.
                if (abort) begin
                    state_d = IDLE;
                end else if (addr_ready) begin
                    if (rem_q != '0) begin
                        addr_d = addr_next;
                        rem_d  = rem_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign ld_ready   = (state_q == IDLE);
    assign addr_valid = (state_q == ISSUE);
    assign busy       = (state_q == ISSUE);
    assign addr_last  = (state_q == ISSUE) && (rem_q == '0);
    assign addr_out   = addr_q;

endmodule

// File: tb/tb_mar_burst.sv
// Randomized self-checking bench for mar_burst against an arithmetic burst model.
// Expected addresses follow the MAR_WRAP_BURST_EN setting of the build.
module tb_mar_burst;

    localparam int ADDR_W = 5;
    localparam int LEN_W  = 3;
    localparam int STRIDE = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [LEN_W-1:0]  ld_len;
    logic              abort;
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_out;
    logic              addr_last;
    logic              busy;

    int errors = 0;
    int checks = 0;

    mar_burst #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_len     (ld_len),
        .abort      (abort),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_out   (addr_out),
        .addr_last  (addr_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Address of beat k of a burst starting at base.
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int k);
`ifdef MAR_WRAP_BURST_EN
        int lo;
        lo = (int'(base) % (1 << LEN_W) + k * STRIDE) % (1 << LEN_W);
        return ADDR_W'((int'(base) / (1 << LEN_W)) * (1 << LEN_W) + lo);
`else
        return ADDR_W'((int'(base) + k * STRIDE) % (1 << ADDR_W));
`endif
    endfunction

    // Loads one burst from IDLE and follows it beat by beat against the model.
    task automatic run_burst(input logic [ADDR_W-1:0] base, input int len,
                             input int stall_beat, input int stall_n,
                             input int abort_beat, input int rst_beat,
                             input bit rnd_ready, input bit abort_on_load,
                             input string nm);
        int  k, stalls, cyc;
        bit  done, ab, rdy, was_reset;
        logic [ADDR_W-1:0] ea;
        k = 0; stalls = 0; cyc = 0; done = 0; was_reset = 0;
        ld_addr    = base;
        ld_len     = LEN_W'(len);
        ld_valid   = 1'b1;
        abort      = abort_on_load;
        addr_ready = 1'b0;
        step();
        ld_valid = 1'b0;
        abort    = 1'b0;
        ld_addr  = ADDR_W'($urandom);
        ld_len   = LEN_W'($urandom);
        while (!done && cyc < 200) begin
            cyc++;
            ea = exp_addr(base, k);
            checks++;
            if (addr_valid !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0 ||
                addr_out !== ea || addr_last !== (k == len)) begin
                errors++;
                $display("FAIL %s beat%0d: valid=%b busy=%b ld_ready=%b addr=%h last=%b, required 1 1 0 addr=%h last=%b",
                         nm, k, addr_valid, busy, ld_ready, addr_out, addr_last, ea, (k == len));
            end
            if (k == rst_beat) begin
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if (addr_valid !== 1'b0 || addr_out !== '0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_rst: valid=%b addr=%h ld_ready=%b busy=%b, required 0 00 1 0",
                             nm, addr_valid, addr_out, ld_ready, busy);
                end
                #1 rst_n = 1'b1;
                was_reset = 1;
                done = 1;
            end else begin
                if (k == stall_beat && stalls < stall_n) begin
                    rdy = 0;
                    stalls++;
                end else if (rnd_ready) begin
                    rdy = ($urandom_range(0, 1) == 1);
                end else begin
                    rdy = 1;
                end
                ab = (k == abort_beat);
                addr_ready = rdy;
                abort      = ab;
                step();
                abort = 1'b0;
                if (ab) done = 1;
                else if (rdy) begin
                    if (k == len) done = 1;
                    else k++;
                end
            end
        end
        addr_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: burst still active after %0d cycles, required completion", nm, cyc);
        end else if (!was_reset) begin
            checks++;
            if (addr_valid !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0 || addr_last !== 1'b0) begin
                errors++;
                $display("FAIL %s end: valid=%b ld_ready=%b busy=%b last=%b, required 0 1 0 0",
                         nm, addr_valid, ld_ready, busy, addr_last);
            end
        end else begin
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_len = '0; abort = 1'b0; addr_ready = 1'b0;
        #12;
        checks++;
        if (addr_valid !== 1'b0 || addr_out !== '0 || ld_ready !== 1'b1 || busy !== 1'b0 || addr_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: valid=%b addr=%h ld_ready=%b busy=%b last=%b, required 0 00 1 0 0",
                     addr_valid, addr_out, ld_ready, busy, addr_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_burst(5'h04, 3, -1, 0, -1, -1, 0, 0, "basic");
        checks++;
        if (addr_out !== exp_addr(5'h04, 3)) begin
            errors++;
            $display("FAIL basic_hold: addr=%h, required %h", addr_out, exp_addr(5'h04, 3));
        end
        // Asynchronous reset from IDLE with a non-zero held address.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (addr_out !== '0 || addr_valid !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: addr=%h valid=%b ld_ready=%b busy=%b, required 00 0 1 0",
                     addr_out, addr_valid, ld_ready, busy);
        end
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        run_burst(5'h04, 3, 1, 3, -1, -1, 0, 0, "backpressure");
        step();
    endtask

    task automatic test_wrap();
        run_burst(5'h1E, 3, -1, 0, -1, -1, 0, 0, "wrap");
        step();
        run_burst(5'h1F, 7, -1, 0, -1, -1, 0, 0, "wrap_full");
        step();
    endtask

    task automatic test_abort();
        run_burst(5'h04, 3, -1, 0, 1, -1, 0, 0, "abort");
        step();
        checks++;
        if (addr_valid !== 1'b0 || addr_out === exp_addr(5'h04, 2)) begin
            errors++;
            $display("FAIL abort_no_beat: valid=%b addr=%h, required 0 and not %h",
                     addr_valid, addr_out, exp_addr(5'h04, 2));
        end
        run_burst(5'h09, 2, -1, 0, -1, -1, 0, 1, "abort_idle_load");
        step();
    endtask

    task automatic test_async_reset();
        run_burst(5'h04, 3, -1, 0, -1, 2, 0, 0, "rst_mid");
        run_burst(5'h10, 0, -1, 0, -1, -1, 0, 0, "after_rst");
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_burst(ADDR_W'($urandom), int'($urandom_range(0, 7)), -1, 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                      -1, 1, 0, "random");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
